level_change_recorder: RTL and testbench

LEVEL_CHANGE_RECORDER -- requirements
Module: level_change_recorder

---
 rtl/level_change_recorder.sv | 106 ++++++++++
 tb/tb_level_change_recorder.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/level_change_recorder.sv
// Samples a bus every cycle and queues {value, timestamp} records into a FWFT FIFO
// whenever the value changes while enabled; overflowing records are counted and dropped.
module level_change_recorder #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned TS_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [WIDTH-1:0]         sig_in,
    input  logic                     rec_ready,
    output logic                     rec_valid,
    output logic [WIDTH-1:0]         rec_value,
    output logic [TS_WIDTH-1:0]      rec_timestamp,
    input  logic                     clr_overflow,
    output logic                     rec_overflow,
    output logic [7:0]               drop_count,
    output logic [$clog2(DEPTH):0]   fill_level
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned RW = WIDTH + TS_WIDTH;

    logic [TS_WIDTH-1:0] ts_q, ts_d;
    logic [WIDTH-1:0]    s_val_q, p_val_q;
    logic [TS_WIDTH-1:0] s_ts_q;
    logic                s_en_q, arm_q, arm_d;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]         count_q, count_d;
    logic                ovf_q, ovf_d;
    logic [7:0]          drop_q, drop_d;
    logic [RW-1:0]       mem_q [DEPTH];
    logic [RW-1:0]       head;

    logic push, pop, full, drop, do_push;

    always_comb begin
        full    = (count_q == DEPTH[AW:0]);
        pop     = (count_q != '0) && rec_ready;
        push    = s_en_q && (arm_q || (s_val_q != p_val_q));
        drop    = push && full && !pop;
        do_push = push && !drop;

        ts_d     = enable ? ts_q + {{(TS_WIDTH-1){1'b0}}, 1'b1} : ts_q;
        // Arm re-triggers on every disabled sample, so the first enabled one always records
        arm_d    = ~s_en_q;
        wr_ptr_d = do_push ? wr_ptr_q + {{(AW-1){1'b0}}, 1'b1} : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + {{(AW-1){1'b0}}, 1'b1} : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !pop) count_d = count_q + {{AW{1'b0}}, 1'b1};
        if (!do_push && pop) count_d = count_q - {{AW{1'b0}}, 1'b1};

        ovf_d  = ovf_q;
        drop_d = drop_q;
        // A clear coinciding with a drop leaves exactly that one drop recorded
        if (clr_overflow) begin
            ovf_d  = drop;
            drop_d = drop ? 8'd1 : 8'd0;
        end else if (drop) begin
            ovf_d  = 1'b1;
            drop_d = (drop_q == 8'hFF) ? drop_q : drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ts_q     <= '0;
            s_val_q  <= '0;
            p_val_q  <= '0;
            s_ts_q   <= '0;
            s_en_q   <= 1'b0;
            arm_q    <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            drop_q   <= '0;
        end else begin
            ts_q     <= ts_d;
            s_val_q  <= sig_in;
            p_val_q  <= s_val_q;
            s_ts_q   <= ts_q;
            s_en_q   <= enable;
            arm_q    <= arm_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            drop_q   <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_push) mem_q[wr_ptr_q] <= {s_val_q, s_ts_q};
    end

    always_comb begin
        head          = mem_q[rd_ptr_q];
        rec_valid     = (count_q != '0);
        rec_value     = rec_valid ? head[RW-1:TS_WIDTH] : '0;
        rec_timestamp = rec_valid ? head[TS_WIDTH-1:0] : '0;
        rec_overflow  = ovf_q;
        drop_count    = drop_q;
        fill_level    = count_q;
    end
endmodule

// File: tb/tb_level_change_recorder.sv
// Scoreboard bench for level_change_recorder (WIDTH=32, DEPTH=16, TS_WIDTH=4 for wrap coverage).
module tb_level_change_recorder;
    localparam int unsigned W = 32;
    localparam int unsigned D = 16;
    localparam int unsigned T = 4;

    logic         clk = 1'b0;
    logic         rst, enable, rec_ready, clr_overflow;
    logic [W-1:0] sig_in;
    logic         rec_valid, rec_overflow;
    logic [W-1:0] rec_value;
    logic [T-1:0] rec_timestamp;
    logic [7:0]   drop_count;
    logic [4:0]   fill_level;

    level_change_recorder #(.WIDTH(W), .DEPTH(D), .TS_WIDTH(T)) dut (
        .clk(clk), .rst(rst), .enable(enable), .sig_in(sig_in),
        .rec_ready(rec_ready), .rec_valid(rec_valid), .rec_value(rec_value),
        .rec_timestamp(rec_timestamp), .clr_overflow(clr_overflow),
        .rec_overflow(rec_overflow), .drop_count(drop_count), .fill_level(fill_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] val;
        logic [T-1:0] ts;
    } rec_t;

    rec_t         sb[$];
    rec_t         m_prec;
    logic         m_pend, m_arm, m_ovf, m_fresh;
    logic [W-1:0] m_prev;
    logic [T-1:0] m_ts;
    int           m_cnt;
    int           n_chk = 0;
    int           n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: drive, compare against the model at negedge, advance the model at posedge.
    task automatic cyc(input logic r, input logic en, input logic [W-1:0] v,
                       input logic rdy, input logic clr);
        logic popm, fullm, dropm;
        rst = r; enable = en; sig_in = v; rec_ready = rdy; clr_overflow = clr;
        @(negedge clk);
        chk("valid", rec_valid, sb.size() != 0);
        chk("fill", fill_level, sb.size());
        chk("ovf", rec_overflow, m_ovf);
        chk("drops", drop_count, m_cnt);
        if (sb.size() != 0) begin
            chk("value", rec_value, sb[0].val);
            chk("tstamp", rec_timestamp, sb[0].ts);
        end else if (m_fresh) begin
            chk("value0", rec_value, 0);
            chk("tstamp0", rec_timestamp, 0);
        end
        @(posedge clk);
        if (r) begin
            sb.delete();
            m_ts = '0; m_pend = 1'b0; m_arm = 1'b1; m_prev = '0;
            m_ovf = 1'b0; m_cnt = 0; m_fresh = 1'b1;
        end else begin
            popm  = (sb.size() != 0) && rdy;
            fullm = (sb.size() == D);
            dropm = m_pend && fullm && !popm;
            if (popm) void'(sb.pop_front());
            if (m_pend && !dropm) begin
                sb.push_back(m_prec);
                m_fresh = 1'b0;
            end
            if (clr) begin
                m_ovf = dropm;
                m_cnt = dropm ? 1 : 0;
            end else if (dropm) begin
                m_ovf = 1'b1;
                if (m_cnt != 255) m_cnt++;
            end
            m_pend     = en && (m_arm || (v != m_prev));
            m_prec.val = v;
            m_prec.ts  = m_ts;
            m_arm      = !en;
            m_prev     = v;
            if (en) m_ts = m_ts + 1'b1;
        end
        #1;
    endtask

    initial begin
        m_pend = 1'b0; m_arm = 1'b1; m_ovf = 1'b0; m_fresh = 1'b1;
        m_prev = '0; m_ts = '0; m_cnt = 0;
        m_prec.val = '0; m_prec.ts = '0;
        rst = 1'b1; enable = 1'b0; sig_in = '0; rec_ready = 1'b0; clr_overflow = 1'b0;

        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("rst_fill", fill_level, 0);

        // Constant value after release: one initial record, valid two cycles after enable
        cyc(0, 1, 32'hA5, 0, 0);
        chk("a5_lat1", rec_valid, 0);
        cyc(0, 1, 32'hA5, 0, 0);
        chk("a5_lat2", rec_valid, 1);
        cyc(0, 1, 32'hA5, 0, 0);
        cyc(0, 1, 32'hA5, 0, 0);
        chk("a5_one", fill_level, 1);
        chk("a5_val", rec_value, 32'hA5);
        chk("a5_ts", rec_timestamp, 0);
        cyc(0, 1, 32'hA5, 1, 0);
        cyc(0, 1, 32'hA5, 1, 0);

        // Back-to-back changes at ts 10 and 11 with consumer always ready
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 14; i++)
            cyc(0, 1, (i < 10) ? 32'h0 : ((i == 10) ? 32'h1 : 32'h2), 1, 0);

        // Changes while disabled are ignored; re-enable records current value
        for (int i = 0; i < 3; i++) cyc(0, 0, 32'h3 + i, 1, 0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 32'h5, 1, 0);

        // Timestamp wrap: changes at ts 15 then 0
        for (int i = 0; i < 16 && m_ts != 4'hF; i++) cyc(0, 1, 32'h5, 1, 0);
        cyc(0, 1, 32'h6, 1, 0);
        cyc(0, 1, 32'h7, 1, 0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 32'h7, 1, 0);

        // Overflow: initial + 19 changes into a 16-entry FIFO
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) cyc(0, 1, 32'h100 + i, 0, 0);
        cyc(0, 1, 32'h113, 0, 0);
        cyc(0, 1, 32'h113, 0, 0);
        chk("full_fill", fill_level, 16);
        chk("full_ovf", rec_overflow, 1);
        chk("full_drops", drop_count, 4);

        // Push and pop together while full
        cyc(0, 1, 32'h200, 0, 0);
        cyc(0, 1, 32'h200, 1, 0);
        chk("pp_fill", fill_level, 16);
        chk("pp_drops", drop_count, 4);

        cyc(0, 1, 32'h200, 0, 1);
        chk("clr_ovf", rec_overflow, 0);
        chk("clr_drops", drop_count, 0);
        for (int i = 0; i < 20; i++) cyc(0, 1, 32'h200, 1, 0);
        chk("drained", fill_level, 0);

        // Clear coinciding with a drop
        for (int i = 0; i < 18; i++) cyc(0, 1, 32'h300 + i, 0, 0);
        cyc(0, 1, 32'h400, 0, 0);
        cyc(0, 1, 32'h400, 0, 1);
        chk("clrdrop_cnt", drop_count, 1);
        chk("clrdrop_ovf", rec_overflow, 1);
        cyc(0, 1, 32'h400, 0, 0);

        // Reset with stored records and a pending change
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) cyc(0, 1, 32'h10 + i, 0, 0);
        chk("pre_rst_fill", fill_level, 5);
        cyc(1, 1, 32'h15, 0, 0);
        chk("rst_valid", rec_valid, 0);
        chk("rst_fill2", fill_level, 0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 32'h15, 0, 0);
        chk("post_rst_fill", fill_level, 1);
        chk("post_rst_val", rec_value, 32'h15);
        chk("post_rst_ts", rec_timestamp, 0);
        cyc(0, 1, 32'h15, 1, 0);
        cyc(0, 1, 32'h15, 1, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
